// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the default
// baud divider used by both the receive and transmit paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_RATE_FREQ_BAUD = 87;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop in the same cycle as a push
// frees the slot first, so a push into a full FIFO with a pop always lands.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_data_av,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  assign w_wr   = i_push && (!w_full || w_pop);

  assign o_drop    = i_push && w_full && !w_pop;
  assign o_full    = w_full;
  assign o_count   = r_count;
  assign o_data_av = (r_count != '0);
  // Head is forced to zero while empty so stale storage never shows.
  assign o_data    = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT receive FIFO, with sticky overrun and
// framing-error flags.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int unsigned RATE_FREQ_BAUD = UART_RATE_FREQ_BAUD,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              rd,
  input  logic                              clr,
  output logic [UART_DATA_BITS-1:0]         data_out,
  output logic                              data_av,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              busy,
  output logic                              overrun,
  output logic                              frame_err
);

  localparam int unsigned BW    = $clog2(RATE_FREQ_BAUD + 1);
  localparam int unsigned BITW  = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] HALF = BW'(RATE_FREQ_BAUD / 2);
  localparam logic [BW-1:0] FULL = BW'(RATE_FREQ_BAUD);

  rx_state_e                 r_state, w_state_nxt;
  logic                      r_sync1, r_sync2;
  logic [BW-1:0]             r_baud, w_baud_nxt;
  logic [BITW-1:0]           r_bit, w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                      r_overrun, r_frame_err;
  logic                      w_rx_s, w_tick, w_push, w_fe_set, w_drop;

  assign w_rx_s = r_sync2;
  // Counter is loaded with the distance to the next sample; expiry is at 1.
  assign w_tick = (r_baud == BW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= ST_IDLE;
      r_baud      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_state     <= w_state_nxt;
      r_baud      <= w_baud_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_overrun   <= w_drop   | (r_overrun   & ~clr);
      r_frame_err <= w_fe_set | (r_frame_err & ~clr);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_fe_set    = 1'b0;
    if (r_state != ST_IDLE && r_state != ST_WAIT_IDLE && !w_tick) begin
      w_baud_nxt = r_baud - BW'(1);
    end
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_bit_nxt   = '0;
          w_baud_nxt  = HALF;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_baud_nxt  = FULL;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_baud_nxt  = FULL;
          w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit == BITW'(UART_DATA_BITS - 1)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BITW'(1);
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_rx_s) begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_fe_set    = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (r_shift),
    .i_pop     (rd),
    .o_data    (data_out),
    .o_data_av (data_av),
    .o_full    (full),
    .o_count   (count),
    .o_drop    (w_drop)
  );

  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with an integrated receive FIFO, the inbound counterpart of the UART transmitter on the microcontroller's serial port. It samples the asynchronous `rx` line at the system clock, assembles 8N1 frames and buffers the received bytes. The peripheral controller (or a DMA engine) pops bytes through a first-word-fall-through read port.

## Interface
- `RATE_FREQ_BAUD`, 87: system clocks per bit (10 MHz, 115200 bps); legal minimum 4.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `rd`  in  1  pop FIFO head; ignored when `data_av`=0.
- `clr`  in  1  clears `overrun` and `frame_err`.
- `data_out`  out  8  FIFO head byte; valid while `data_av`=1.
- `data_av`  out  1  FIFO not empty.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `count`  out  $clog2(FIFO_DEPTH+1)  bytes stored.
- `busy`  out  1  receiver outside IDLE.
- `overrun`  out  1  sticky; byte dropped because FIFO was full.
- `frame_err`  out  1  sticky; stop bit sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer reset to 1; the FSM uses the synchronized value `rx_s` only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: `rx_s`=0 -> START, bit counter cleared, baud counter loaded with `RATE_FREQ_BAUD/2` (floor).
- START: at baud counter expiry, `rx_s`=1 -> IDLE (glitch, nothing stored); `rx_s`=0 -> DATA, baud counter loaded with `RATE_FREQ_BAUD`.
- DATA: at each expiry shift `rx_s` into the shift register LSB first; after 8 bits -> STOP.
- STOP: at expiry, `rx_s`=1 -> push byte, IDLE. `rx_s`=0 -> set `frame_err`, discard byte, WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1 (break handling), then IDLE.
- Push with FIFO full and no pop in the same cycle: byte dropped, `overrun` set, FIFO contents unchanged.
- Push and pop in the same cycle: the pop is applied first, so the push always succeeds and `count` is unchanged, including when the FIFO is full.
- `rd` with FIFO empty: no effect; pointers and `count` do not move.
- Pointers wrap modulo `FIFO_DEPTH`.
- `clr` and a new error in the same cycle: the error wins and the flag stays set.
- Reset values: `data_out`=0, `data_av`=0, `full`=0, `count`=0, `busy`=0, `overrun`=0, `frame_err`=0, FSM=IDLE, synchronizer=1.
- Reset mid-frame aborts the frame and empties the FIFO.

## Timing
- Synchronizer latency: 2 clocks from an `rx` edge to `rx_s`.
- Sample points, counted from the first cycle with `rx_s`=0 (t0): t0 + H + k·R for k=0..9, where H=`RATE_FREQ_BAUD/2` and R=`RATE_FREQ_BAUD`. k=0 is the start bit, k=1..8 are data bits, k=9 is the stop bit.
- With defaults, the stop bit is sampled at t0+826. The push registers on that edge, so `data_av`/`data_out` are valid from t0+827.
- `busy` is high from t0+1 until the cycle after the stop-bit sample.
- FWFT read: after a `rd` edge, the next head appears on `data_out` in the same following cycle; `count` updates on the same edge.
- Sustained throughput: one byte per 10·R clocks; no dead cycles between back-to-back frames, because IDLE re-arms on the stop-sample edge.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum;
  - `UART_DATA_BITS`=8;
  - the default `RATE_FREQ_BAUD`=87, shared with the transmitter.
- Sub-module `sync_fifo`, parameterised on width and depth. It provides FWFT read, `full`, `count`, and the pop-before-push rule. It can later be reused on the transmit side.
- The synchronizer, baud counter, bit counter, shift register and FSM stay in `uart_rx_fifo`.

## Test plan
- Send 0xA5 at R=87 -> `data_av` rises at t0+827 with `data_out`=0xA5; `frame_err`=0, `overrun`=0; `rd` pulse -> `data_av`=0, `count`=0.
- Low glitch of 20 clocks on `rx` -> no push; `busy` returns to 0 at t0+44; state IDLE.
- Frame 0x3C with stop bit forced low, then line held low 2000 clocks -> `frame_err`=1, no push, `busy` held until `rx` returns high; `clr` -> `frame_err`=0.
- Send 9 bytes 0x01..0x09 with `FIFO_DEPTH`=8 and no reads -> `full`=1, `count`=8, `overrun`=1; reads return 0x01..0x08 in order.
- FIFO full, `rd` asserted on the stop-sample cycle of byte 0x55 -> no overrun, `count` stays 8, 0x55 is read last.
- Assert `rst_n` low at mid-data bit 4 with 3 bytes queued -> all outputs at reset values immediately; the next full frame 0x7E is received correctly.
